glyph_fb_writer: RTL and testbench
==================================

Name: glyph_fb_writer

Overview:
- Downstream of the glyph row renderer. Consumes its per-pixel stream: pix_wr, pix_x (delta_x), 4-bit pix_data and the row-done pulse.
- Packs 8 pixels of 4 bits into one 32-bit framebuffer word and computes the word address from the cell origin.
- Issues the word to the framebuffer write port through a 2-entry buffer, because the renderer cannot stall.

Parameters:
- FB_ADDR_W, 16, framebuffer word-address width.
- LINE_WORDS, 80, words per scanline (640 px / 8).
- MAX_ROWS, 480, visible scanlines; rows >= MAX_ROWS are clipped.
- COL_W, 7, width of cell_col.
- ROW_W, 9, width of cell_row.

Ports:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- cell_load  in  1  one-cycle pulse: latch a new cell row origin.
- cell_col  in  COL_W  word column, 0..LINE_WORDS-1.
- cell_row  in  ROW_W  top scanline of glyph cell.
- cell_dy  in  4  glyph row offset, 0..15.
- pix_wr  in  1  pixel valid strobe.
- pix_x  in  8  pixel index within the glyph row; only [2:0] is used.
- pix_data  in  4  pixel colour.
- pix_done  in  1  high together with pix_wr on the last pixel (x=7).
- fb_wr_en  out  1  write request.
- fb_wr_addr  out  FB_ADDR_W  word address.
- fb_wr_data  out  32  packed pixels; pixel n at bits [4n+3:4n].
- fb_wr_ready  in  1  framebuffer accepts the word when fb_wr_en and fb_wr_ready are both high.
- busy  out  1  collecting a word or buffer not empty.
- overflow  out  1  sticky: a word was dropped because the buffer was full.
- clipped  out  1  sticky: a word was discarded because its row was out of range.

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - buffer empty;
  - assembly word 0.
- FSM states:
  - IDLE -> ADDR on cell_load.
  - ADDR (1 cycle): addr_reg = (cell_row + cell_dy) * LINE_WORDS + cell_col, truncated to FB_ADDR_W. Sets row_bad if (cell_row + cell_dy) >= MAX_ROWS; the sum is computed at ROW_W+1 bits. -> COLLECT.
  - COLLECT: each pix_wr writes pix_data into nibble pix_x[2:0] of the assembly word. pix_wr together with pix_done -> push {addr_reg, word}, unless row_bad. -> IDLE.
- Operand latching: cell_col, cell_row and cell_dy are latched on cell_load. The assembly word is cleared to 0 on cell_load, so unwritten pixels are written as colour 0.
- pix_wr in IDLE is ignored and has no effect.
- pix_wr during ADDR is accepted into the word; the first pixel may follow cell_load by 1 cycle.
- cell_load during ADDR or COLLECT aborts the current word: partial data is discarded, nothing is pushed, and the FSM restarts in ADDR.
- pix_done with pix_x[2:0] != 7 still closes the word.
- Buffer: 2-entry FIFO of {addr, data}.
  - fb_wr_en = !empty.
  - fb_wr_addr / fb_wr_data = head entry, held stable until accepted.
  - Pop when fb_wr_en && fb_wr_ready.
  - Push and pop in the same cycle: allowed when full, count unchanged.
  - Push when full with no pop: the new word is dropped and overflow is set.
- Clip: a closed word with row_bad is not pushed; clipped is set.
- Sticky flags: overflow and clipped clear only on reset.
- busy = (FSM != IDLE) || !empty.
- Latency: pix_done cycle -> fb_wr_en high on the next cycle when the buffer was empty.

Optional Feature:
- Macro: GLYPH_FB_WRITER_MASK_EN.
- With the macro:
  - adds output fb_wr_mask [7:0], 1 bit per nibble;
  - a mask bit is set only for nibbles written since cell_load;
  - the mask is stored in the FIFO alongside the data;
  - unwritten nibbles keep their framebuffer content (transparent background).
- Without the macro: no mask port; all 8 nibbles are always written.

Decomposition:
- Shared package holds:
  - PIX_W=4 and PIX_PER_WORD=8;
  - FSM state encodings IDLE/ADDR/COLLECT;
  - FB word width of 32.
- Natural sub-module: glyph_fb_wfifo, the 2-entry {addr, data[, mask]} FIFO with push/pop/full/empty.

Test Plan:
- Basic word: cell_load col=3 row=16 dy=2; 8 pixels x=0..7 with data=x; ready=1 -> one write, addr=18*80+3=1443, data=0x76543210.
- Backpressure: ready=0, three words closed back-to-back -> first two held in order, third dropped, overflow=1. Raise ready -> exactly 2 writes.
- Clip: row=470, dy=12 (sum 482) -> no fb_wr_en, clipped=1. Row 479 is still written.
- Abort: cell_load after 4 pixels, then a full new row -> only the second word is written; its data has no leftover nibbles.
- Partial row: pixels x=0,1 only, then pix_done -> data=0x00000010. With GLYPH_FB_WRITER_MASK_EN, mask=0x03.
- Reset mid-operation: reset_n low with the buffer full and in COLLECT -> fb_wr_en=0, busy=0, flags=0 immediately, and the next cell works normally.

Source files
------------

// File: rtl/glyph_fb_writer_pkg.sv
// Shared constants for the glyph framebuffer writer: pixel/word geometry
// and the writer FSM state encodings.
package glyph_fb_writer_pkg;

  localparam int PIX_W        = 4;
  localparam int PIX_PER_WORD = 8;
  localparam int FB_DATA_W    = 32;
  localparam int MASK_W       = PIX_PER_WORD;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ADDR    = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;

endpackage

// File: rtl/glyph_fb_writer_if.sv
// Framebuffer write port. Handshake: a word transfers on every clk edge where
// fb_wr_en and fb_wr_ready are both high; addr/data/mask hold until then.
// fb_wr_mask exists only when GLYPH_FB_WRITER_MASK_EN is defined.
interface glyph_fb_writer_if #(
  parameter int FB_ADDR_W = 16
) ();
  import glyph_fb_writer_pkg::*;

  logic                 fb_wr_en;
  logic [FB_ADDR_W-1:0] fb_wr_addr;
  logic [FB_DATA_W-1:0] fb_wr_data;
  logic                 fb_wr_ready;
`ifdef GLYPH_FB_WRITER_MASK_EN
  logic [MASK_W-1:0]    fb_wr_mask;
`endif

  modport master (
    input  fb_wr_ready,
    output fb_wr_en,
    output fb_wr_addr,
`ifdef GLYPH_FB_WRITER_MASK_EN
    output fb_wr_mask,
`endif
    output fb_wr_data
  );

  modport slave (
    output fb_wr_ready,
    input  fb_wr_en,
    input  fb_wr_addr,
`ifdef GLYPH_FB_WRITER_MASK_EN
    input  fb_wr_mask,
`endif
    input  fb_wr_data
  );

endinterface

// File: rtl/glyph_fb_wfifo.sv
// Two-entry FIFO for {addr, data[, mask]} framebuffer words. A push while full
// is accepted only if a pop happens in the same cycle; otherwise it is ignored.
module glyph_fb_wfifo #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // When full with a pop, wr_ptr == rd_ptr: the new word lands in the slot
  // being vacated and becomes the tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/glyph_fb_writer.sv
// Packs the glyph renderer's 4-bit pixel stream into 32-bit framebuffer words
// and queues them to the write port. Optional per-nibble write mask: GLYPH_FB_WRITER_MASK_EN.
module glyph_fb_writer
  import glyph_fb_writer_pkg::*;
#(
  parameter int FB_ADDR_W  = 16,
  parameter int LINE_WORDS = 80,
  parameter int MAX_ROWS   = 480,
  parameter int COL_W      = 7,
  parameter int ROW_W      = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cell_load,
  input  logic [COL_W-1:0] cell_col,
  input  logic [ROW_W-1:0] cell_row,
  input  logic [3:0]       cell_dy,
  input  logic             pix_wr,
  input  logic [7:0]       pix_x,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_done,
  glyph_fb_writer_if.master fb,
  output logic             busy,
  output logic             overflow,
  output logic             clipped,
  output logic [1:0]       dbg_state
);

`ifdef GLYPH_FB_WRITER_MASK_EN
  localparam int ENTRY_W = FB_ADDR_W + FB_DATA_W + MASK_W;
`else
  localparam int ENTRY_W = FB_ADDR_W + FB_DATA_W;
`endif

  logic [1:0]           state;
  logic [COL_W-1:0]     col_q;
  logic [ROW_W-1:0]     row_q;
  logic [3:0]           dy_q;
  logic [FB_ADDR_W-1:0] addr_reg;
  logic                 row_bad;
  logic [FB_DATA_W-1:0] word;
  logic [FB_DATA_W-1:0] word_next;
  logic [MASK_W-1:0]    mask_q;
  logic [MASK_W-1:0]    mask_next;
  logic [ROW_W:0]       row_sum;
  logic                 accept_pix;
  logic                 close_word;
  logic                 push_req;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   head;
  logic                 pix_x_unused;

  assign pix_x_unused = ^pix_x[7:3];

  // Extra bit keeps rows past 511 from wrapping back into the visible range.
  assign row_sum = {1'b0, row_q} + {{(ROW_W-3){1'b0}}, dy_q};

  assign accept_pix = pix_wr && !cell_load &&
                      ((state == ST_ADDR) || (state == ST_COLLECT));
  assign close_word = pix_wr && pix_done && !cell_load && (state == ST_COLLECT);
  assign push_req   = close_word && !row_bad;

  always_comb begin
    word_next = word;
    mask_next = mask_q;
    if (accept_pix) begin
      word_next[{pix_x[2:0], 2'b00} +: PIX_W] = pix_data;
      mask_next[pix_x[2:0]]                   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      dy_q     <= '0;
      addr_reg <= '0;
      row_bad  <= 1'b0;
      word     <= '0;
      mask_q   <= '0;
    end else if (cell_load) begin
      state  <= ST_ADDR;
      col_q  <= cell_col;
      row_q  <= cell_row;
      dy_q   <= cell_dy;
      word   <= '0;
      mask_q <= '0;
    end else begin
      word   <= word_next;
      mask_q <= mask_next;
      case (state)
        ST_ADDR: begin
          addr_reg <= FB_ADDR_W'(32'(row_sum) * 32'(LINE_WORDS) + 32'(col_q));
          row_bad  <= (32'(row_sum) >= 32'(MAX_ROWS));
          state    <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (close_word) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      clipped  <= 1'b0;
    end else begin
      if (push_req && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (close_word && row_bad) clipped <= 1'b1;
    end
  end

`ifdef GLYPH_FB_WRITER_MASK_EN
  assign push_data = {addr_reg, word_next, mask_next};
  assign {fb.fb_wr_addr, fb.fb_wr_data, fb.fb_wr_mask} = head;
`else
  logic mask_unused;
  assign mask_unused = ^mask_next;
  assign push_data   = {addr_reg, word_next};
  assign {fb.fb_wr_addr, fb.fb_wr_data} = head;
`endif

  assign fifo_pop    = !fifo_empty && fb.fb_wr_ready;
  assign fb.fb_wr_en = !fifo_empty;

  glyph_fb_wfifo #(.W(ENTRY_W)) u_wfifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_glyph_fb_writer.sv
// Bench for glyph_fb_writer: directed cases with literal expectations plus a
// randomized phase, all checked every cycle against a word-level model.
module tb_glyph_fb_writer;
  import glyph_fb_writer_pkg::*;

  localparam int FB_ADDR_W  = 16;
  localparam int LINE_WORDS = 80;
  localparam int MAX_ROWS   = 480;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       cell_load = 1'b0;
  logic [6:0] cell_col = '0;
  logic [8:0] cell_row = '0;
  logic [3:0] cell_dy = '0;
  logic       pix_wr = 1'b0;
  logic [7:0] pix_x = '0;
  logic [3:0] pix_data = '0;
  logic       pix_done = 1'b0;
  logic       busy;
  logic       overflow;
  logic       clipped;
  logic [1:0] dbg_state;

  glyph_fb_writer_if #(.FB_ADDR_W(FB_ADDR_W)) fb ();

  glyph_fb_writer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cell_load (cell_load),
    .cell_col  (cell_col),
    .cell_row  (cell_row),
    .cell_dy   (cell_dy),
    .pix_wr    (pix_wr),
    .pix_x     (pix_x),
    .pix_data  (pix_data),
    .pix_done  (pix_done),
    .fb        (fb),
    .busy      (busy),
    .overflow  (overflow),
    .clipped   (clipped),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  bit rand_ready = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [FB_ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]          exp_q[$];
  logic [7:0]           exp_mask_q[$];
  bit                   m_active;
  logic [3:0]           m_nib[8];
  logic [7:0]           m_mask;
  int                   m_col, m_row, m_dy;
  bit                   m_ovf, m_clip;
  bit                   m_popped, m_close;
  logic [31:0]          m_word;

  initial begin
    m_active = 0; m_ovf = 0; m_clip = 0; m_mask = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_addr_q.delete(); exp_q.delete(); exp_mask_q.delete();
        m_active = 0; m_ovf = 0; m_clip = 0;
      end else begin
        m_popped = (exp_q.size() != 0) && fb.fb_wr_ready;
        m_close  = 0;
        if (cell_load) begin
          m_active = 1;
          for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
          m_mask = '0;
          m_col = int'(cell_col); m_row = int'(cell_row); m_dy = int'(cell_dy);
        end else if (m_active && pix_wr) begin
          m_nib[pix_x[2:0]]  = pix_data;
          m_mask[pix_x[2:0]] = 1'b1;
          if (pix_done) begin
            m_active = 0;
            if (m_row + m_dy >= MAX_ROWS) m_clip = 1;
            else m_close = 1;
          end
        end
        if (m_popped) begin
          void'(exp_addr_q.pop_front()); void'(exp_q.pop_front()); void'(exp_mask_q.pop_front());
        end
        if (m_close) begin
          if (exp_q.size() < 2) begin
            for (int i = 0; i < 8; i++) m_word[4*i +: 4] = m_nib[i];
            exp_addr_q.push_back(FB_ADDR_W'((m_row + m_dy) * LINE_WORDS + m_col));
            exp_q.push_back(m_word);
            exp_mask_q.push_back(m_mask);
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("wr_en", fb.fb_wr_en, exp_q.size() != 0);
    if (exp_q.size() != 0 && fb.fb_wr_en) begin
      check("wr_addr", fb.fb_wr_addr, exp_addr_q[0]);
      check("wr_data", fb.fb_wr_data, exp_q[0]);
`ifdef GLYPH_FB_WRITER_MASK_EN
      check("wr_mask", fb.fb_wr_mask, exp_mask_q[0]);
`endif
    end
    check("busy", busy, m_active || (exp_q.size() != 0));
    check("overflow", overflow, m_ovf);
    check("clipped", clipped, m_clip);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) fb.fb_wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(int col, int row, int dy);
    cell_load = 1'b1;
    cell_col  = 7'(col);
    cell_row  = 9'(row);
    cell_dy   = 4'(dy);
    tick();
    cell_load = 1'b0;
  endtask

  task automatic pix(int x, int d, bit done);
    pix_wr   = 1'b1;
    pix_x    = 8'(x);
    pix_data = 4'(d);
    pix_done = done;
    tick();
    pix_wr   = 1'b0;
    pix_done = 1'b0;
  endtask

  task automatic full_row(int col, int row, int dy);
    load(col, row, dy);
    for (int x = 0; x < 8; x++) pix(x, x, x == 7);
  endtask

  // ---------------- stimulus ----------------
  int n_wr;
  int n_pix;
  bit abort;

  initial begin
    fb.fb_wr_ready = 1'b0;
    idle(2);
    check("rst_en", fb.fb_wr_en, 0);
    check("rst_addr", fb.fb_wr_addr, 0);
    check("rst_data", fb.fb_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {overflow, clipped}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset_n = 1'b1;
    idle(1);

    // Basic word: one-cycle latency from pix_done to fb_wr_en
    fb.fb_wr_ready = 1'b1;
    full_row(3, 16, 2);
    check("basic_en", fb.fb_wr_en, 1);
    check("basic_addr", fb.fb_wr_addr, 1443);
    check("basic_data", fb.fb_wr_data, 32'h7654_3210);
    idle(2);
    check("basic_drained", fb.fb_wr_en, 0);

    // Backpressure: third word dropped
    fb.fb_wr_ready = 1'b0;
    full_row(10, 0, 0);
    full_row(11, 1, 0);
    full_row(12, 2, 0);
    check("bp_overflow", overflow, 1);
    check("bp_head_addr", fb.fb_wr_addr, 10);
    fb.fb_wr_ready = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 6; i++) begin
      if (fb.fb_wr_en) n_wr++;
      tick();
    end
    check("bp_writes", n_wr, 2);

    // Clip at 482, last visible row 479 still written
    full_row(5, 470, 12);
    check("clip_en", fb.fb_wr_en, 0);
    check("clip_flag", clipped, 1);
    full_row(5, 479, 0);
    check("row479_en", fb.fb_wr_en, 1);
    check("row479_addr", fb.fb_wr_addr, 38325);
    idle(2);

    // Abort: partial high nibbles discarded, new word starts clean
    load(1, 0, 0);
    for (int x = 4; x < 8; x++) pix(x, 15, 1'b0);
    load(2, 1, 0);
    for (int x = 0; x < 4; x++) pix(x, x + 1, x == 3);
    check("abort_addr", fb.fb_wr_addr, 82);
    check("abort_data", fb.fb_wr_data, 32'h0000_4321);
`ifdef GLYPH_FB_WRITER_MASK_EN
    check("abort_mask", fb.fb_wr_mask, 8'h0F);
`endif
    idle(2);

    // Partial row
    load(0, 2, 0);
    pix(0, 0, 1'b0);
    pix(1, 1, 1'b1);
    check("partial_addr", fb.fb_wr_addr, 160);
    check("partial_data", fb.fb_wr_data, 32'h0000_0010);
`ifdef GLYPH_FB_WRITER_MASK_EN
    check("partial_mask", fb.fb_wr_mask, 8'h03);
`endif
    idle(2);

    // pix_wr while idle is ignored
    pix(3, 5, 1'b1);
    idle(1);
    check("idle_pix_en", fb.fb_wr_en, 0);
    check("idle_pix_busy", busy, 0);

    // Reset mid-operation: buffer full and FSM collecting
    fb.fb_wr_ready = 1'b0;
    full_row(0, 3, 0);
    full_row(1, 3, 0);
    load(2, 3, 0);
    for (int x = 0; x < 3; x++) pix(x, 9, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_en", fb.fb_wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_flags", {overflow, clipped}, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    idle(2);
    reset_n = 1'b1;
    fb.fb_wr_ready = 1'b1;
    idle(1);
    full_row(3, 16, 2);
    check("post_rst_addr", fb.fb_wr_addr, 1443);
    check("post_rst_data", fb.fb_wr_data, 32'h7654_3210);
    idle(2);

    // Randomized rows with random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 80; r++) begin
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
        if ($urandom_range(0, 4) == 0) pix(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        else tick();
      end
      load(int'($urandom_range(0, 79)),
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 479)) : int'($urandom_range(440, 511)),
           int'($urandom_range(0, 15)));
      n_pix = int'($urandom_range(1, 8));
      abort = (r != 79) && ($urandom_range(0, 7) == 0);
      for (int k = 0; k < n_pix; k++) begin
        if ((k == 0 && n_pix == 1) || $urandom_range(0, 3) == 0) tick();
        pix(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), (k == n_pix - 1) && !abort);
      end
    end
    rand_ready = 1'b0;
    fb.fb_wr_ready = 1'b1;
    idle(6);
    check("final_drained", fb.fb_wr_en, 0);
    check("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
